// File: rtl/pre_if_stage_pkg.sv
// Shared definitions for the pre-IF fetch engine: FSM state encoding,
// the default reset fetch address and a small alignment helper.
package pre_if_stage_pkg;

  typedef enum logic [1:0] {
    PREIF_IDLE = 2'd0,
    PREIF_REQ  = 2'd1,
    PREIF_WAIT = 2'd2,
    PREIF_HOLD = 2'd3
  } preif_state_t;

  localparam logic [31:0] PREIF_RESET_PC = 32'h1c000000;

  // A fetch address is illegal unless it is word aligned.
  function automatic logic pc_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pre_if_stage.sv
// Pre-IF fetch engine. Owns the fetch PC, issues one instruction-bus read
// at a time and hands {pc, inst, adef} packets to the IF stage.
// Redirects (flush over branch) may arrive in any cycle; a response that
// belongs to a superseded PC is dropped through the cancel flag.
// Optional build macro PREIF_BYPASS_EN: forward read data straight to the
// IF stage in the data_ok cycle when it can accept, skipping HOLD.
module pre_if_stage
  import pre_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PREIF_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fs_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic        inst_ram_req,
  output logic        inst_ram_wr,
  output logic [1:0]  inst_ram_size,
  output logic [3:0]  inst_ram_wstrb,
  output logic [31:0] inst_ram_addr,
  output logic [31:0] inst_ram_wdata,
  input  logic        inst_ram_addr_ok,
  input  logic        inst_ram_data_ok,
  input  logic [31:0] inst_ram_rdata,
  output logic        to_fs_valid,
  output logic [31:0] to_fs_pc,
  output logic [31:0] to_fs_inst,
  output logic        to_fs_adef
);

  preif_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         cancel_q, cancel_d;
  logic         redir_pend_q, redir_pend_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic [31:0]  pkt_pc_q, pkt_pc_d;
  logic [31:0]  pkt_inst_q, pkt_inst_d;
  logic         pkt_adef_q, pkt_adef_d;
  logic         req_c;
  logic         redir;
  logic [31:0]  tgt;
`ifdef PREIF_BYPASS_EN
  logic         bypass_fire;
`endif

  assign redir = flush | br_taken;
  assign tgt   = flush ? flush_target : br_target;

  // State and packet registers; synchronous reset restarts fetch at RESET_PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= PREIF_REQ;
      pc_q         <= RESET_PC;
      cancel_q     <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 32'd0;
      pkt_pc_q     <= 32'd0;
      pkt_inst_q   <= 32'd0;
      pkt_adef_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cancel_q     <= cancel_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      pkt_pc_q     <= pkt_pc_d;
      pkt_inst_q   <= pkt_inst_d;
      pkt_adef_q   <= pkt_adef_d;
    end
  end

  // Next-state logic: bus handshake, redirect bookkeeping and packet capture.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cancel_d     = cancel_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    pkt_pc_d     = pkt_pc_q;
    pkt_inst_d   = pkt_inst_q;
    pkt_adef_d   = pkt_adef_q;
    req_c        = 1'b0;
`ifdef PREIF_BYPASS_EN
    bypass_fire  = 1'b0;
`endif
    case (state_q)
      PREIF_REQ: begin
        if (pc_misaligned(pc_q)) begin
          if (redir) begin
            pc_d = tgt;
          end else begin
            pkt_pc_d   = pc_q;
            pkt_inst_d = 32'd0;
            pkt_adef_d = 1'b1;
            state_d    = PREIF_HOLD;
          end
        end else begin
          req_c = 1'b1;
          if (inst_ram_addr_ok) begin
            cancel_d     = redir | redir_pend_q;
            redir_pc_d   = redir ? tgt : redir_pc_q;
            redir_pend_d = 1'b0;
            state_d      = PREIF_WAIT;
          end else if (redir) begin
            redir_pend_d = 1'b1;
            redir_pc_d   = tgt;
          end
        end
      end
      PREIF_WAIT: begin
        if (inst_ram_data_ok) begin
          if (cancel_q | redir) begin
            pc_d         = redir ? tgt : redir_pc_q;
            cancel_d     = 1'b0;
            redir_pend_d = 1'b0;
            state_d      = PREIF_REQ;
          end else begin
`ifdef PREIF_BYPASS_EN
            if (fs_allowin) begin
              bypass_fire = 1'b1;
              pc_d        = pc_q + 32'd4;
              state_d     = PREIF_REQ;
            end else begin
              pkt_pc_d   = pc_q;
              pkt_inst_d = inst_ram_rdata;
              pkt_adef_d = 1'b0;
              state_d    = PREIF_HOLD;
            end
`else
            pkt_pc_d   = pc_q;
            pkt_inst_d = inst_ram_rdata;
            pkt_adef_d = 1'b0;
            state_d    = PREIF_HOLD;
`endif
          end
        end else if (redir) begin
          cancel_d   = 1'b1;
          redir_pc_d = tgt;
        end
      end
      PREIF_HOLD: begin
        if (redir) begin
          pc_d    = tgt;
          state_d = PREIF_REQ;
        end else if (fs_allowin) begin
          if (pkt_adef_q) begin
            state_d = PREIF_IDLE;
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = PREIF_REQ;
          end
        end
      end
      PREIF_IDLE: begin
        if (redir) begin
          pc_d    = tgt;
          state_d = PREIF_REQ;
        end
      end
      default: state_d = PREIF_REQ;
    endcase
  end

  assign inst_ram_req   = req_c & ~reset;
  assign inst_ram_wr    = 1'b0;
  assign inst_ram_size  = 2'd2;
  assign inst_ram_wstrb = 4'h0;
  assign inst_ram_addr  = pc_q;
  assign inst_ram_wdata = 32'd0;

`ifdef PREIF_BYPASS_EN
  assign to_fs_valid = ((state_q == PREIF_HOLD) & ~redir | bypass_fire) & ~reset;
  assign to_fs_pc    = bypass_fire ? pc_q           : pkt_pc_q;
  assign to_fs_inst  = bypass_fire ? inst_ram_rdata : pkt_inst_q;
  assign to_fs_adef  = bypass_fire ? 1'b0           : pkt_adef_q;
`else
  assign to_fs_valid = (state_q == PREIF_HOLD) & ~redir & ~reset;
  assign to_fs_pc    = pkt_pc_q;
  assign to_fs_inst  = pkt_inst_q;
  assign to_fs_adef  = pkt_adef_q;
`endif

endmodule
